serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 24 ++
 rtl/serial_add_ctrl_bit_counter.sv | 43 ++++
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the serial adder controller and its bench:
//   DEFAULT_WIDTH - default operand width / number of serial add cycles
//   state_t       - controller state encoding (IDLE=0, LOAD=1, ADD=2, DONE=3)
//   majority3     - carry-out of a one-bit full adder
// ----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ADD  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Full-adder carry: true when at least two of the three inputs are set.
   function automatic logic majority3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_counter.sv
// ----------------------------------------------------------------------------
// bit_counter
// Counts serial add cycles. Cleared while the controller is in LOAD, advances
// once per ADD cycle and saturates at WIDTH-1 instead of wrapping.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear to 0 (has priority over enable)
//   enable    - advance by one
//   tc        - terminal count, high while the count equals WIDTH-1
// ----------------------------------------------------------------------------
module bit_counter
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] count_r;

   // Cycle counter: clear wins, then saturating increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LAST)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = (count_r == LAST);

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
// Controller for an LSB-first bit-serial adder. Operands are handed to two
// external shift registers (loaded by sr_load, shifting right otherwise); the
// controller consumes their bit-0 outputs one per cycle, accumulates the sum
// serially and presents {cout,sum} with a one-cycle done pulse.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   start, a_in, b_in,cin- request and operands, sampled only in IDLE
//   a_bit, b_bit         - bit 0 of the external A/B shift registers
//   sr_load              - load strobe for the external shift registers
//   sr_data_a, sr_data_b - captured operands to load into the shift registers
//   busy                 - high during LOAD and ADD
//   done                 - one-cycle result-valid pulse
//   sum, cout            - result, held until the next completed addition
// ----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             sr_load,
   output logic [WIDTH-1:0] sr_data_a,
   output logic [WIDTH-1:0] sr_data_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_t           state_r;
   logic             carry_r;
   logic [WIDTH-1:0] sum_shift_r;
   logic             last_bit_s;
   logic             sum_bit_s;
   logic             carry_next_s;
   logic [WIDTH-1:0] shift_next_s;

   bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_r == ST_LOAD),
      .enable (state_r == ST_ADD),
      .tc     (last_bit_s)
   );

   // One full-adder slice; the new sum bit enters at the MSB so that after
   // WIDTH shifts the first (LSB) result bit has arrived at bit 0.
   always_comb begin
      sum_bit_s    = a_bit ^ b_bit ^ carry_r;
      carry_next_s = majority3(a_bit, b_bit, carry_r);
      shift_next_s = {sum_bit_s, sum_shift_r[WIDTH-1:1]};
   end

   // Controller FSM with registered strobes and result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         carry_r     <= 1'b0;
         sum_shift_r <= '0;
         sum         <= '0;
         cout        <= 1'b0;
         sr_data_a   <= '0;
         sr_data_b   <= '0;
         sr_load     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sr_data_a <= a_in;
                  sr_data_b <= b_in;
                  carry_r   <= cin;
                  sr_load   <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= ST_LOAD;
               end else begin
                  sr_load <= 1'b0;
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               // The shift registers load on this edge; bits stream from the next cycle.
               sr_load     <= 1'b0;
               busy        <= 1'b1;
               sum_shift_r <= '0;
               state_r     <= ST_ADD;
            end
            ST_ADD: begin
               carry_r     <= carry_next_s;
               sum_shift_r <= shift_next_s;
               if (last_bit_s) begin
                  sum     <= shift_next_s;
                  cout    <= carry_next_s;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  busy    <= 1'b1;
                  state_r <= ST_ADD;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               sr_load <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Bench for serial_add_ctrl with behavioural external shift registers, an
// arithmetic reference model and a queue-based scoreboard.
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   typedef struct {
      logic [W:0] val;
      int         done_edge;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         cin = 1'b0;
   logic         a_bit, b_bit;
   logic         sr_load, busy, done, cout;
   logic [W-1:0] sr_data_a, sr_data_b, sum;

   logic [W-1:0] sr_a, sr_b;

   int   tests = 0;
   int   fails = 0;
   int   edge_cnt = 0;
   int   next_free = 0;
   int   last_acc = -1000;
   logic [W:0] held = '0;
   exp_t exp_q[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .sr_load   (sr_load),
      .sr_data_a (sr_data_a),
      .sr_data_b (sr_data_b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   // External LSB-first shift registers sharing clk/rst with the controller.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_a <= '0;
         sr_b <= '0;
      end else if (sr_load) begin
         sr_a <= sr_data_a;
         sr_b <= sr_data_b;
      end else begin
         sr_a <= sr_a >> 1;
         sr_b <= sr_b >> 1;
      end
   end
   assign a_bit = sr_a[0];
   assign b_bit = sr_b[0];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model and monitor. Acceptance follows the timing rules alone:
   // a start is taken on the first edge at least W+3 edges after the last one.
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt++;
         if (rst) begin
            exp_q.delete();
            next_free = 0;
            last_acc  = -1000;
            held      = '0;
         end else if (start && edge_cnt >= next_free) begin
            exp_t e;
            e.val       = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin};
            e.done_edge = edge_cnt + W + 1;
            exp_q.push_back(e);
            last_acc  = edge_cnt;
            next_free = edge_cnt + W + 3;
         end
         #1;
         if (!rst) begin
            chk("sr_load", sr_load, (edge_cnt == last_acc));
            chk("busy", busy, (edge_cnt >= last_acc && edge_cnt <= last_acc + W));
            chk("done", done, (edge_cnt == last_acc + W + 1));
            chk("busy_and_done", busy & done, 1'b0);
            if (done) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_done", 1'b1, 1'b0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("done_latency", edge_cnt, e.done_edge);
                  held = e.val;
               end
            end
            chk("result_hold", {cout, sum}, held);
         end
      end
   end

   // Wait (bounded) until the next edge would accept a start.
   task automatic wait_idle();
      int k = 0;
      while (edge_cnt + 1 < next_free && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("idle_timeout", 1'b1, 1'b0);
   endtask

   // Issue one start pulse; operands change right after to show they are not re-read.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      wait_idle();
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      cin   = c;
      @(negedge clk);
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      cin   = 1'($urandom);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_sum", sum, '0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sr_load", sr_load, 1'b0);
      chk("rst_sr_data", {sr_data_a, sr_data_b}, '0);
      rst = 1'b0;
      @(negedge clk);

      // Directed arithmetic cases
      issue(8'h0F, 8'h01, 1'b0);
      issue(8'hFF, 8'h01, 1'b0);
      issue(8'hFF, 8'hFF, 1'b1);

      // A second start during ADD must be ignored
      issue(8'h21, 8'h42, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1;
      a_in  = 8'hAA;
      b_in  = 8'h55;
      cin   = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset during the 4th ADD cycle aborts the operation
      issue(8'h5A, 8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_sum", sum, '0);
      chk("abort_cout", cout, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_sr_data", {sr_data_a, sr_data_b}, '0);
      @(negedge clk);
      rst = 1'b0;
      issue(8'h12, 8'h34, 1'b0);

      // start held high: back-to-back additions
      wait_idle();
      start = 1'b1;
      a_in  = 8'h80;
      b_in  = 8'h80;
      cin   = 1'b0;
      repeat (3 * (W + 3)) @(negedge clk);
      start = 1'b0;

      // Random operands with occasional ignored starts
      for (int i = 0; i < 40; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, W)) @(negedge clk);
            start = 1'b1;
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            @(negedge clk);
            start = 1'b0;
         end
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("pending_results", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
